// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage RV32M multiply/divide unit:
// funct3 encodings, FSM state type and the architectural special-case constants.
package muldiv_pkg;

   // funct3 encodings of the M-extension R-type ops
   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   // Quotient for division by zero, and the most negative 32-bit value
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // funct3[2] separates the divide/remainder group from the multiplies
   function automatic logic is_div_op(input logic [2:0] funct3);
      return funct3[2];
   endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ID/EX -> muldiv -> EX/MEM connection bundle.
//
// Handshake: the ID/EX side holds valid_i and the operand fields stable for as
// long as busy_o is high (busy_o is the pipeline stall). An op is accepted on a
// rising edge where the unit is idle, valid_i=1 and flush_i=0. done_o is a
// single-cycle pulse with result_o/rd_o valid; busy_o is low in that cycle so
// the pipeline advances on the edge that ends it. flush_i kills the op.
interface ex_muldiv_if;
   logic        valid_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   modport master (
      output valid_i, funct3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
      input  busy_o, done_o, result_o, rd_o
   );

   modport slave (
      input  valid_i, funct3_i, rs1_data_i, rs2_data_i, rd_i, flush_i,
      output busy_o, done_o, result_o, rd_o
   );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative core working on unsigned magnitudes.
// Multiply: acc = {hi, multiplier}; each step adds the multiplicand into hi
// when acc[0] is set and shifts right, leaving the 64-bit product in acc.
// Divide (restoring): acc = {remainder, dividend}; each step shifts left and
// trial-subtracts the divisor, leaving {remainder, quotient} in acc.
module muldiv_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   output logic [2*XLEN-1:0] acc_nxt,
   output logic              last
);

   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   b_q;
   logic              div_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [XLEN:0]     sum;
   logic [XLEN:0]     rem;
   logic [XLEN:0]     diff;

   // One shift-add or shift-subtract step from the current accumulator
   always_comb begin
      sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem  = acc_q[2*XLEN-1:XLEN-1];
      diff = rem - {1'b0, b_q};
      if (div_q) begin
         if (!diff[XLEN]) acc_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
         else             acc_nxt = {rem[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = {sum, acc_q[XLEN-1:1]};
      end
   end

   assign last = (cnt_q == CNT_W'(XLEN - 1));

   // Load operands on start, then advance one step per enabled cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         b_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else if (start) begin
         acc_q <= {{XLEN{1'b0}}, op_a};
         b_q   <= op_b;
         div_q <= is_div;
         cnt_q <= '0;
      end else if (step) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: control FSM, operand sign conditioning, special-case
// detection (divide by zero, signed overflow) and final sign fix-up around
// the iterative magnitude core.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic  clk_i,
   input  logic  rst_i,
   ex_muldiv_if.slave bus,
   output state_t dbg_state
);

   state_t state_q, state_d;

   logic            accept;
   logic            is_div;
   logic            signed1, signed2;
   logic            s1, s2;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div0, ovf, special;
   logic [XLEN-1:0] spec_res;

   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic            s1_q, s2_q;

   logic [2*XLEN-1:0] acc_nxt;
   logic              last;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quot, remd, fin;

   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_out_q;

   assign accept = (state_q == IDLE) & bus.valid_i & ~bus.flush_i;
   assign is_div = is_div_op(bus.funct3_i);

   // Which operands are interpreted as signed for the incoming funct3
   always_comb begin
      signed1 = 1'b0;
      signed2 = 1'b0;
      case (bus.funct3_i)
         OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
            signed1 = 1'b1;
            signed2 = 1'b1;
         end
         OP_MULHSU: signed1 = 1'b1;
         default: ;
      endcase
   end

   assign s1    = signed1 & bus.rs1_data_i[XLEN-1];
   assign s2    = signed2 & bus.rs2_data_i[XLEN-1];
   assign a_abs = s1 ? -bus.rs1_data_i : bus.rs1_data_i;
   assign b_abs = s2 ? -bus.rs2_data_i : bus.rs2_data_i;

   // Ops whose result is fixed by the ISA and needs no iteration
   assign div0    = is_div & (bus.rs2_data_i == '0);
   assign ovf     = is_div & ~bus.funct3_i[0] & (bus.rs1_data_i == INT_MIN) &
                    (bus.rs2_data_i == '1);
   assign special = div0 | ovf;

   // Architectural results for the special cases (funct3[1] selects REM*)
   always_comb begin
      spec_res = '0;
      if (div0)     spec_res = bus.funct3_i[1] ? bus.rs1_data_i : DIV0_QUOT;
      else if (ovf) spec_res = bus.funct3_i[1] ? '0 : INT_MIN;
   end

   muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
      .clk     (clk_i),
      .rst     (rst_i),
      .start   (accept & ~special),
      .step    (state_q == CALC),
      .is_div  (is_div),
      .op_a    (a_abs),
      .op_b    (b_abs),
      .acc_nxt (acc_nxt),
      .last    (last)
   );

   // Sign fix-up of the magnitude result produced by the final step
   always_comb begin
      prod = (s1_q ^ s2_q) ? -acc_nxt : acc_nxt;
      quot = (s1_q ^ s2_q) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
      remd = s1_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      case (f3_q)
         OP_MUL:                      fin = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fin = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:             fin = quot;
         default:                     fin = remd;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; DONE always returns to IDLE so a held valid_i is not re-taken
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (accept) state_d = special ? DONE : CALC;
         CALC: begin
            if (bus.flush_i) state_d = IDLE;
            else if (last)   state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Capture op context at acceptance
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         f3_q <= '0;
         rd_q <= '0;
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else if (accept) begin
         f3_q <= bus.funct3_i;
         rd_q <= bus.rd_i;
         s1_q <= s1;
         s2_q <= s2;
      end
   end

   // Result registers update only on the edge entering DONE and hold otherwise
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         result_q <= '0;
         rd_out_q <= '0;
      end else if (accept & special) begin
         result_q <= spec_res;
         rd_out_q <= bus.rd_i;
      end else if ((state_q == CALC) & last & ~bus.flush_i) begin
         result_q <= fin;
         rd_out_q <= rd_q;
      end
   end

   assign bus.busy_o   = ~rst_i & ((state_q == CALC) | accept);
   assign bus.done_o   = (state_q == DONE) & ~bus.flush_i;
   assign bus.result_o = result_q;
   assign bus.rd_o     = rd_out_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: a reference model computes each op's result
// from the RV32M rules with plain 64-bit arithmetic, a scoreboard queue holds
// {rd, result} per issued op, and a monitor checks every done_o pulse.
module tb_ex_muldiv;
   import muldiv_pkg::*;

   logic   clk;
   logic   rst;
   state_t dbg_state;

   ex_muldiv_if bus ();

   ex_muldiv #(.XLEN(32), .CNT_W(6)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;
   int n_exp    = 0;
   logic [36:0] exp_q[$];

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference model straight from the RV32M definitions
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      logic [31:0] r;
      r = '0;
      case (f)
         OP_MUL: begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            r = p[31:0];
         end
         OP_MULH: begin
            p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            r = p[63:32];
         end
         OP_MULHSU: begin
            p = {{32{a[31]}}, a} * {32'b0, b};
            r = p[63:32];
         end
         OP_MULHU: begin
            p = {32'b0, a} * {32'b0, b};
            r = p[63:32];
         end
         OP_DIV: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = $signed(a) / $signed(b);
         end
         OP_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = $signed(a) % $signed(b);
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Monitor: every done_o pulse must match the head of the expected queue
   task automatic monitor();
      logic [36:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.done_o) begin
            n_done++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done result=%h rd=%0d expected=none",
                        bus.result_o, bus.rd_o);
            end else begin
               e = exp_q.pop_front();
               check("done_result", bus.result_o, e[31:0]);
               check("done_rd", 32'(bus.rd_o), 32'(e[36:32]));
            end
         end
      end
   endtask

   // Issue one op starting now (in an IDLE cycle); wait for done and count busy cycles
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int exp_busy,
                         input bit hold, input string name);
      logic [31:0] m;
      int busy_cnt;
      bit seen;
      m = model(f, a, b);
      check({"model_", name}, m, lit);
      exp_q.push_back({rd, m});
      n_exp++;
      bus.valid_i    = 1'b1;
      bus.funct3_i   = f;
      bus.rs1_data_i = a;
      bus.rs2_data_i = b;
      bus.rd_i       = rd;
      busy_cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (bus.done_o) begin
            seen = 1'b1;
            break;
         end
         if (bus.busy_o) busy_cnt++;
      end
      check({"done_seen_", name}, 32'(seen), 32'd1);
      check({"busy_cycles_", name}, busy_cnt, exp_busy);
      @(posedge clk);
      #1;
      if (!hold) bus.valid_i = 1'b0;
   endtask

   task automatic start_abort_op();
      bus.valid_i    = 1'b1;
      bus.funct3_i   = OP_MUL;
      bus.rs1_data_i = 32'd1000;
      bus.rs2_data_i = 32'd3000;
      bus.rd_i       = 5'd9;
      repeat (11) @(negedge clk);
   endtask

   initial begin
      rst            = 1'b1;
      bus.valid_i    = 1'b1;
      bus.funct3_i   = OP_MUL;
      bus.rs1_data_i = 32'd3;
      bus.rs2_data_i = 32'd4;
      bus.rd_i       = 5'd1;
      bus.flush_i    = 1'b0;
      fork
         monitor();
      join_none

      // Reset state, with valid_i high to confirm busy_o stays low in reset
      repeat (3) @(negedge clk);
      #1;
      check("reset_busy", 32'(bus.busy_o), 32'd0);
      check("reset_done", 32'(bus.done_o), 32'd0);
      check("reset_result", bus.result_o, 32'd0);
      check("reset_rd", 32'(bus.rd_o), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      bus.valid_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Multiply group
      run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b0, "mul_7_m3");
      run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 33, 1'b0, "mulh_min");
      run_op(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 5'd7,  32'h4000_0000, 33, 1'b0, "mulhu_min");
      run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33, 1'b0, "mulhsu_m1");
      run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 33, 1'b0, "mulhu_max");

      // Divide group
      run_op(OP_DIVU, 32'd100,        32'd7,         5'd11, 32'd14,        33, 1'b0, "divu_100_7");
      run_op(OP_REMU, 32'd100,        32'd7,         5'd12, 32'd2,         33, 1'b0, "remu_100_7");
      run_op(OP_REM,  32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFF, 33, 1'b0, "rem_m7_2");
      run_op(OP_DIV,  32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFD, 33, 1'b0, "div_m7_2");
      run_op(OP_DIV,  32'd20,         32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, 33, 1'b0, "div_20_m3");
      run_op(OP_REM,  32'd20,         32'hFFFF_FFFD, 5'd16, 32'd2,         33, 1'b0, "rem_20_m3");

      // Result holds while idle
      repeat (3) @(negedge clk);
      #1;
      check("hold_result", bus.result_o, 32'd2);
      check("hold_rd", 32'(bus.rd_o), 32'd16);
      @(posedge clk);
      #1;

      // Special cases: one busy cycle straight into DONE
      run_op(OP_DIV,  32'd1234,       32'd0,         5'd17, 32'hFFFF_FFFF, 1, 1'b0, "div_by0");
      run_op(OP_REM,  32'd5,          32'd0,         5'd18, 32'd5,         1, 1'b0, "rem_by0");
      run_op(OP_DIVU, 32'd77,         32'd0,         5'd19, 32'hFFFF_FFFF, 1, 1'b0, "divu_by0");
      run_op(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1, 1'b0, "div_ovf");
      run_op(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd21, 32'd0,         1, 1'b1, "rem_ovf");
      bus.valid_i = 1'b0;

      // Give the previous result a nonzero value before the reset abort
      run_op(OP_MUL, 32'd6, 32'd7, 5'd22, 32'd42, 33, 1'b0, "mul_6_7");

      // Reset in the middle of CALC
      start_abort_op();
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.busy_o), 32'd0);
      check("midrst_done", 32'(bus.done_o), 32'd0);
      check("midrst_result", bus.result_o, 32'd0);
      check("midrst_rd", 32'(bus.rd_o), 32'd0);
      check("midrst_state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(negedge clk);
      bus.valid_i = 1'b0;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;

      // Flush in the middle of CALC
      start_abort_op();
      bus.flush_i = 1'b1;
      #1;
      check("flush_done", 32'(bus.done_o), 32'd0);
      @(negedge clk);
      #1;
      check("flush_state", 32'(dbg_state), 32'(IDLE));
      check("flush_busy", 32'(bus.busy_o), 32'd0);
      bus.flush_i = 1'b0;
      bus.valid_i = 1'b0;
      repeat (40) @(negedge clk);
      @(posedge clk);
      #1;

      // Back-to-back: valid held through DONE, second op issued right after
      run_op(OP_MUL, 32'd6,         32'd7,         5'd23, 32'd42, 33, 1'b1, "b2b_first");
      run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd24, 32'd1,  33, 1'b0, "b2b_second");

      repeat (40) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      check("done_count", n_done, n_exp);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
